// File: rtl/hop_pipe_array.sv
// Array of independent valid/data shift pipelines with per-channel local reset
// and a global warm-up FSM that raises ready once the pipelines have had time to fill.

module hop_chan #(
    parameter int DEPTH  = 2,
    parameter int WIDTH  = 1,
    parameter int CW     = 2,
    parameter bit LASYNC = 1'b1
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             rst_ch,
    input  logic             en,
    input  logic             start_vld,
    input  logic [WIDTH-1:0] start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [CW-1:0]    fill_cnt
);
    logic                         s0_vld;
    logic [WIDTH-1:0]             s0_dat;
    logic [DEPTH-1:1]             tl_vld;
    logic [DEPTH-1:1][WIDTH-1:0]  tl_dat;
    logic [DEPTH-1:0]             all_vld;
    logic [DEPTH-1:0][WIDTH-1:0]  all_dat;

    assign all_vld = {tl_vld, s0_vld};
    assign all_dat = {tl_dat, s0_dat};

    // Stage 0 only answers to the global reset so the channel input is never lost.
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            s0_vld <= 1'b0;
            s0_dat <= '0;
        end else if (en) begin
            s0_vld <= start_vld;
            s0_dat <= start;
        end
    end

    generate
        if (LASYNC) begin : g_arst
            logic lrst;
            assign lrst = rst1 | rst_ch;
            always_ff @(posedge clock0 or posedge lrst) begin
                if (lrst) begin
                    tl_vld <= '0;
                    tl_dat <= '0;
                end else if (en) begin
                    tl_vld <= all_vld[DEPTH-2:0];
                    tl_dat <= all_dat[DEPTH-2:0];
                end
            end
        end else begin : g_srst
            always_ff @(posedge clock0 or posedge rst1) begin
                if (rst1) begin
                    tl_vld <= '0;
                    tl_dat <= '0;
                end else if (rst_ch) begin
                    tl_vld <= '0;
                    tl_dat <= '0;
                end else if (en) begin
                    tl_vld <= all_vld[DEPTH-2:0];
                    tl_dat <= all_dat[DEPTH-2:0];
                end
            end
        end
    endgenerate

    // Popcount taken straight off the stage flops, so it tracks async clears too.
    always_comb begin
        fill_cnt = '0;
        for (int k = 0; k < DEPTH; k++) fill_cnt = fill_cnt + CW'(all_vld[k]);
    end

    assign dout     = tl_dat[DEPTH-1];
    assign dout_vld = tl_vld[DEPTH-1];
endmodule

module hop_pipe_array #(
    parameter int                NUM_CH     = 4,
    parameter int                DEPTH      = 2,
    parameter int                WIDTH      = 1,
    parameter logic [NUM_CH-1:0] LRST_ASYNC = {NUM_CH{1'b1}}
) (
    input  logic                               clock0,
    input  logic                               rst1,
    input  logic [NUM_CH-1:0]                  rst_ch,
    input  logic [NUM_CH-1:0]                  en,
    input  logic [NUM_CH*WIDTH-1:0]            start,
    input  logic [NUM_CH-1:0]                  start_vld,
    output logic [NUM_CH*WIDTH-1:0]            dout,
    output logic [NUM_CH-1:0]                  dout_vld,
    output logic [NUM_CH*$clog2(DEPTH+1)-1:0]  fill_cnt,
    output logic                               ready
);
    localparam int CW = $clog2(DEPTH+1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hop_chan #(
            .DEPTH  (DEPTH),
            .WIDTH  (WIDTH),
            .CW     (CW),
            .LASYNC (LRST_ASYNC[i])
        ) u_ch (
            .clock0    (clock0),
            .rst1      (rst1),
            .rst_ch    (rst_ch[i]),
            .en        (en[i]),
            .start_vld (start_vld[i]),
            .start     (start[i*WIDTH +: WIDTH]),
            .dout      (dout[i*WIDTH +: WIDTH]),
            .dout_vld  (dout_vld[i]),
            .fill_cnt  (fill_cnt[i*CW +: CW])
        );
    end

    typedef enum logic [1:0] {ST_WAIT, ST_FILL, ST_RUN} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;

    // Warm-up: one edge to leave WAIT, then DEPTH edges counting in FILL.
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            state <= ST_WAIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    state <= ST_FILL;
                    cnt   <= '0;
                end
                ST_FILL: begin
                    if (cnt == CW'(DEPTH-1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_WAIT;
            endcase
        end
    end
endmodule
